mem_arbiter: RTL

//  Sits directly below the processor's fetch and memory stages, between the I-cache and D-cache miss ports and the single main-memory port.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the memory arbiter.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W  = 32;
  localparam int ARB_LINE_W  = 128;
  localparam int ARB_TIMEOUT = 255;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_GRANT_I = 3'd1,
    ARB_GRANT_D = 3'd2,
    ARB_RESP_I  = 3'd3,
    ARB_RESP_D  = 3'd4
  } arb_state_e;

  // Which cache was served most recently (round-robin history).
  typedef enum logic {
    GRANT_ICACHE = 1'b0,
    GRANT_DCACHE = 1'b1
  } grant_e;

  // Clear the byte-offset bits so memory always sees a line-aligned address.
  function automatic logic [ARB_ADDR_W-1:0] line_align(input logic [ARB_ADDR_W-1:0] a);
    return a & ~ARB_ADDR_W'(ARB_LINE_W / 8 - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I$ miss port, D$ miss port and main-memory port.
//
// Handshake rules for every channel in this bundle:
//  - A requester (ic_req / dc_req / mem_req) raises its request together with
//    a stable command and holds it until the matching one-cycle completion
//    pulse (ic_ack / dc_ack / mem_valid). The completion pulse is the "ready";
//    read data is valid only in the cycle of that pulse.
//  - No request may be withdrawn early; if it is, the arbiter still finishes
//    the access and pulses the ack.
interface mem_arbiter_if;

  logic                                 ic_req;
  logic [mem_arbiter_pkg::ARB_ADDR_W-1:0] ic_addr;
  logic                                 ic_ack;
  logic [mem_arbiter_pkg::ARB_LINE_W-1:0] ic_rdata;

  logic                                 dc_req;
  logic                                 dc_we;
  logic [mem_arbiter_pkg::ARB_ADDR_W-1:0] dc_addr;
  logic [mem_arbiter_pkg::ARB_LINE_W-1:0] dc_wdata;
  logic                                 dc_ack;
  logic [mem_arbiter_pkg::ARB_LINE_W-1:0] dc_rdata;

  logic                                 mem_req;
  logic                                 mem_we;
  logic [mem_arbiter_pkg::ARB_ADDR_W-1:0] mem_addr;
  logic [mem_arbiter_pkg::ARB_LINE_W-1:0] mem_wdata;
  logic                                 mem_valid;
  logic [mem_arbiter_pkg::ARB_LINE_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_valid, mem_rdata,
    output ic_ack, ic_rdata,
    output dc_ack, dc_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment side: caches and main memory.
  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_valid, mem_rdata,
    input  ic_ack, ic_rdata,
    input  dc_ack, dc_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises I$ fills, D$ fills and D$ write-backs onto one memory channel,
// with round-robin on ties and a watchdog that aborts a stuck access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output logic        busy,
  output logic        timeout_err,
  output arb_state_e  dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e              state_q;
  grant_e                  last_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    timeout_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic [ARB_ADDR_W-1:0]   mem_addr_q;
  logic [ARB_LINE_W-1:0]   mem_wdata_q;
  logic                    ic_ack_q;
  logic                    dc_ack_q;
  logic [ARB_LINE_W-1:0]   ic_rdata_q;
  logic [ARB_LINE_W-1:0]   dc_rdata_q;
  logic                    pick_i;

  // Round-robin picker: I$ wins when alone, or on a tie when D$ went last.
  always_comb begin
    pick_i = bus.ic_req && (!bus.dc_req || (last_q == GRANT_DCACHE));
  end

  // Arbiter FSM with registered outputs; the command is latched at grant entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      last_q      <= GRANT_DCACHE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (pick_i) begin
              state_q     <= ARB_GRANT_I;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= line_align(bus.ic_addr);
              mem_wdata_q <= '0;
            end else begin
              state_q     <= ARB_GRANT_D;
              mem_we_q    <= bus.dc_we;
              mem_addr_q  <= line_align(bus.dc_addr);
              mem_wdata_q <= bus.dc_we ? bus.dc_wdata : '0;
            end
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          if (bus.mem_valid) begin
            mem_req_q <= 1'b0;
            if (state_q == ARB_GRANT_I) begin
              state_q    <= ARB_RESP_I;
              ic_ack_q   <= 1'b1;
              ic_rdata_q <= bus.mem_rdata;
            end else begin
              state_q  <= ARB_RESP_D;
              dc_ack_q <= 1'b1;
              if (!mem_we_q) dc_rdata_q <= bus.mem_rdata;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Memory never answered: abort with zero data and flag it.
            timeout_q <= 1'b1;
            mem_req_q <= 1'b0;
            if (state_q == ARB_GRANT_I) begin
              state_q    <= ARB_RESP_I;
              ic_ack_q   <= 1'b1;
              ic_rdata_q <= '0;
            end else begin
              state_q  <= ARB_RESP_D;
              dc_ack_q <= 1'b1;
              if (!mem_we_q) dc_rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ARB_RESP_I: begin
          last_q  <= GRANT_ICACHE;
          state_q <= ARB_IDLE;
        end
        ARB_RESP_D: begin
          last_q  <= GRANT_DCACHE;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ic_ack    = ic_ack_q;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != ARB_IDLE);
  assign timeout_err   = timeout_q;
  assign dbg_state     = state_q;

endmodule
